// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement controller.
// The optional accumulator is enabled with TDC_MEAS_CTRL_ACCUM_EN.
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_MEAS = 3'd2,
        ST_PUSH = 3'd3,
        ST_GAP  = 3'd4
    } tdc_state_e;

    localparam int unsigned TDC_CW          = 16;
    localparam int unsigned TDC_TIMEOUT_CYC = 4000;
    localparam int unsigned TDC_GAP_CYC     = 4;

endpackage

// File: rtl/tdc_sat_counter.sv
// Up-counter with synchronous clear and saturation at all ones.
// Shared by the phase timer and the coarse start-to-stop counter.
module tdc_sat_counter
    import tdc_pkg::*;
#(
    parameter int unsigned CW = TDC_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Run controller for a TDC front end: arms, times start->stop, returns results.
// Define TDC_MEAS_CTRL_ACCUM_EN to add the per-run result accumulator.
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned CW          = TDC_CW,
    parameter int unsigned TIMEOUT_CYC = TDC_TIMEOUT_CYC,
    parameter int unsigned GAP_CYC     = TDC_GAP_CYC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_count,
    input  logic          abort,
    output logic          arm,
    input  logic          tdc_start,
    input  logic          tdc_stop,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_coarse,
    output logic          res_timeout,
    output logic          busy,
    output logic          done
`ifdef TDC_MEAS_CTRL_ACCUM_EN
    ,
    output logic [CW+7:0] acc_sum,
    output logic [7:0]    acc_n
`endif
);

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    tdc_state_e    state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [CW-1:0] res_coarse_q, res_coarse_d;
    logic          res_to_q, res_to_d;

    logic [CW-1:0] timer;
    logic [CW-1:0] coarse;
    logic          coarse_clr;
    logic          timer_last;
    logic          hs;
    logic          accept;

    // Timer restarts on every state change, so each phase gets its own budget.
    tdc_sat_counter #(.CW(CW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_d != state_q),
        .en_i    (state_q == ST_WAIT || state_q == ST_MEAS
                  || state_q == ST_GAP),
        .cnt_o   (timer)
    );

    tdc_sat_counter #(.CW(CW)) u_coarse (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (coarse_clr),
        .en_i    (state_q == ST_MEAS),
        .cnt_o   (coarse)
    );

    assign timer_last = (timer >= TO_LAST);
    assign hs     = (state_q == ST_PUSH) && res_ready && !abort;
    assign accept = (state_q == ST_IDLE) && cmd_valid
                    && (cmd_count != 8'd0) && !abort;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        res_coarse_d = res_coarse_q;
        res_to_d     = res_to_q;
        coarse_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_count != 8'd0) begin
                    state_d = ST_WAIT;
                    rem_d   = cmd_count;
                end
            end
            ST_WAIT: begin
                // A stop coincident with the start is dropped here.
                if (tdc_start) begin
                    state_d    = ST_MEAS;
                    coarse_clr = 1'b1;
                end else if (timer_last) begin
                    state_d      = ST_PUSH;
                    res_to_d     = 1'b1;
                    res_coarse_d = '1;
                end
            end
            ST_MEAS: begin
                if (tdc_stop) begin
                    state_d      = ST_PUSH;
                    res_to_d     = 1'b0;
                    res_coarse_d = (&coarse) ? coarse : coarse + 1'b1;
                end else if (timer_last) begin
                    state_d      = ST_PUSH;
                    res_to_d     = 1'b1;
                    res_coarse_d = '1;
                end
            end
            ST_PUSH: begin
                if (res_ready) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end else if (GAP_CYC == 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d    = ST_IDLE;
            rem_d      = rem_q;
            coarse_clr = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= 8'd0;
            res_coarse_q <= '0;
            res_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            res_coarse_q <= res_coarse_d;
            res_to_q     <= res_to_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign arm         = (state_q == ST_WAIT) || (state_q == ST_MEAS);
    assign res_valid   = (state_q == ST_PUSH);
    assign res_coarse  = res_coarse_q;
    assign res_timeout = res_to_q;
    assign done        = hs && (rem_q == 8'd1);

`ifdef TDC_MEAS_CTRL_ACCUM_EN
    logic [CW+7:0] acc_sum_q;
    logic [7:0]    acc_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_sum_q <= '0;
            acc_n_q   <= 8'd0;
        end else if (accept) begin
            acc_sum_q <= '0;
            acc_n_q   <= 8'd0;
        end else if (hs && !res_to_q) begin
            acc_sum_q <= acc_sum_q + {8'd0, res_coarse_q};
            acc_n_q   <= acc_n_q + 8'd1;
        end
    end

    assign acc_sum = acc_sum_q;
    assign acc_n   = acc_n_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl with a cycle-level reference model.
// Accumulator checks compile in when TDC_MEAS_CTRL_ACCUM_EN is defined.
module tb_tdc_meas_ctrl;

    localparam int TO  = 20;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_count;
    logic        abort;
    logic        arm;
    logic        tdc_start;
    logic        tdc_stop;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_coarse;
    logic        res_timeout;
    logic        busy;
    logic        done;
`ifdef TDC_MEAS_CTRL_ACCUM_EN
    logic [23:0] acc_sum;
    logic [7:0]  acc_n;
`endif

    int tests = 0;
    int fails = 0;
    int exp_sum = 0;
    int exp_n = 0;

    tdc_meas_ctrl #(
        .CW          (16),
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_count   (cmd_count),
        .abort       (abort),
        .arm         (arm),
        .tdc_start   (tdc_start),
        .tdc_stop    (tdc_stop),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_coarse  (res_coarse),
        .res_timeout (res_timeout),
        .busy        (busy),
        .done        (done)
`ifdef TDC_MEAS_CTRL_ACCUM_EN
        ,
        .acc_sum     (acc_sum),
        .acc_n       (acc_n)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ks = start offset from the first armed cycle (<0 none),
    // ds = stop offset after the start (<0 none). lat = first res_valid cycle.
    function automatic void model(input int ks, input int ds,
                                  output bit to, output int c,
                                  output int lat);
        if (ks < 0 || ks >= TO) begin
            to = 1; c = 'hFFFF; lat = TO;
        end else if (ds < 0 || ds > TO) begin
            to = 1; c = 'hFFFF; lat = ks + TO + 1;
        end else begin
            to = 0; c = ds; lat = ks + ds + 1;
        end
    endfunction

    task automatic start_cmd(input int n);
        cmd_valid = 1'b1;
        cmd_count = 8'(n);
        #1;
        chk("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("arm_after_accept", arm, 1);
        exp_sum = 0;
        exp_n   = 0;
`ifdef TDC_MEAS_CTRL_ACCUM_EN
        chk("acc_clear", {24'd0, acc_n}, 0);
`endif
    endtask

    // Entered on the first armed cycle; leaves on the next armed cycle or idle.
    task automatic do_meas(input int ks, input int ds, input bit same_stop,
                           input int hold, input bit last);
        bit eto;
        int ec;
        int elat;
        int k;
        int g;
        bit got;
        model(ks, ds, eto, ec, elat);
        got = 0;
        for (k = 0; k < 200; k++) begin
            if (res_valid) begin
                got = 1;
                break;
            end
            tdc_start = (k == ks) || (ks >= 0 && k == ks + 2);
            tdc_stop  = (ks >= 1 && k == ks - 1)
                        || (ks >= 0 && k == ks && same_stop)
                        || (ks >= 0 && ds >= 0 && k == ks + ds);
            step();
        end
        tdc_start = 1'b0;
        tdc_stop  = 1'b0;
        chk("res_valid_seen", got, 1);
        chk("latency", k, elat);
        chk("res_timeout", res_timeout, eto);
        chk("res_coarse", res_coarse, ec);
        chk("arm_in_push", arm, 0);
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tdc_start = 1'b1;
            tdc_stop  = 1'b1;
            #1;
            chk("done_while_held", done, 0);
            step();
            tdc_start = 1'b0;
            tdc_stop  = 1'b0;
            chk("held_valid", res_valid, 1);
            chk("held_coarse", res_coarse, ec);
            chk("held_timeout", res_timeout, eto);
        end
        res_ready = 1'b1;
        #1;
        chk("done_at_hs", done, last);
        if (!eto) begin
            exp_sum += ec;
            exp_n++;
        end
        step();
        res_ready = 1'b0;
        #1;
        if (last) begin
            chk("idle_after_run", busy, 0);
            chk("done_one_cycle", done, 0);
`ifdef TDC_MEAS_CTRL_ACCUM_EN
            chk("acc_sum", acc_sum, exp_sum);
            chk("acc_n", {24'd0, acc_n}, exp_n);
`endif
        end else begin
            g = 0;
            while (!arm && g < 50) begin
                chk("gap_no_valid", res_valid, 0);
                g++;
                step();
            end
            chk("gap_len", g, GAP);
        end
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_count = 8'd0;
        abort     = 1'b0;
        tdc_start = 1'b0;
        tdc_stop  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_arm", arm, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_coarse", res_coarse, 0);
`ifdef TDC_MEAS_CTRL_ACCUM_EN
        chk("rst_acc_sum", acc_sum, 0);
        chk("rst_acc_n", {24'd0, acc_n}, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Single measurement: start 3 after arm, stop 5 later.
        start_cmd(1);
        do_meas(3, 5, 0, 0, 1);

        // Three measurements, second result back-pressured for 10 cycles.
        start_cmd(3);
        do_meas(2, 4, 0, 0, 0);
        do_meas(1, 7, 0, 10, 0);
        do_meas(0, 3, 0, 0, 1);

        // No start: WAIT_START timeout.
        start_cmd(1);
        do_meas(-1, -1, 0, 0, 1);

        // Start and stop together, real stop 2 cycles later.
        start_cmd(1);
        do_meas(2, 2, 1, 0, 1);

        // Abort in MEASURE.
        start_cmd(2);
        step();
        tdc_start = 1'b1;
        step();
        tdc_start = 1'b0;
        step();
        chk("abort_pre_arm", arm, 1);
        abort = 1'b1;
        #1;
        chk("abort_no_done", done, 0);
        step();
        abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_arm", arm, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_ready", cmd_ready, 1);
        tdc_stop = 1'b1;
        step();
        tdc_stop = 1'b0;
        step();
        chk("abort_still_no_valid", res_valid, 0);
        chk("abort_still_no_done", done, 0);
        start_cmd(1);
        do_meas(1, 3, 0, 0, 1);

        // Zero-length run is ignored.
        cmd_valid = 1'b1;
        cmd_count = 8'd0;
        #1;
        chk("zero_no_done", done, 0);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("zero_busy", busy, 0);
        chk("zero_arm", arm, 0);

        // Asynchronous reset in the middle of a run.
        start_cmd(2);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_arm", arm, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("arst_ready", cmd_ready, 1);

`ifdef TDC_MEAS_CTRL_ACCUM_EN
        // Results 4, timeout, 6.
        start_cmd(3);
        do_meas(1, 4, 0, 0, 0);
        do_meas(-1, -1, 0, 0, 0);
        do_meas(0, 6, 0, 0, 1);
        chk("acc_sum_fixed", acc_sum, 10);
        chk("acc_n_fixed", {24'd0, acc_n}, 2);
        step();
        chk("acc_hold", acc_sum, 10);
`endif

        // Randomized runs against the reference model.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 3));
            start_cmd(n);
            for (int m = 0; m < n; m++) begin
                do_meas(int'($urandom_range(0, 23)),
                        int'($urandom_range(1, 22)),
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)),
                        m == n - 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
